// File: rtl/spi_slave_rx.sv
// SPI receive-only slave: synchronizes sclk/cs/mosi into the clk domain,
// assembles one LSB-first byte per cs-low frame and queues complete bytes
// in a small first-word-fall-through FIFO.
module spi_slave_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi,
  output logic [7:0]                    dout,
  output logic                          dvalid,
  input  logic                          dready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LEADIN, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   overlen_q, overlen_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_fall, cs_fall, cs_rise;
  logic push_req, ferr_evt;
  logic pop, full, push_ok, ovf_evt;

  // Synchronizer chains plus one extra sample of sclk/cs for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_fall   = sclk_prev_q & ~sclk_s;
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
  end

  // Synchronizer registers; reset to idle bus levels so reset itself creates no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  // Frame FSM: cs edges dominate; sclk falling edges only count while cs is low.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    overlen_d = overlen_q;
    push_req  = 1'b0;
    ferr_evt  = 1'b0;
    if (cs_fall) begin
      // A fall while already busy is a cs glitch: restart silently.
      state_d   = LEADIN;
      bitcnt_d  = 4'd0;
      shreg_d   = 8'h00;
      overlen_d = 1'b0;
    end else if (cs_rise) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        if (state_q == DONE && !overlen_q) push_req = 1'b1;
        else                               ferr_evt = 1'b1;
      end
    end else if (sclk_fall && !cs_s) begin
      case (state_q)
        LEADIN: state_d = SHIFT;
        SHIFT: begin
          shreg_d[bitcnt_q[2:0]] = mosi_s;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) state_d = DONE;
        end
        DONE:    overlen_d = 1'b1;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Bit counter, shift register and over-length flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q  <= 4'd0;
      shreg_q   <= 8'h00;
      overlen_q <= 1'b0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      overlen_q <= overlen_d;
    end
  end

  // FIFO control: a pop frees the slot, so push-while-full succeeds with a pop.
  always_comb begin
    pop         = (count_q != '0) && dready;
    full        = (count_q == FULL_CNT);
    push_ok     = push_req && (!full || pop);
    ovf_evt     = push_req && full && !pop;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = ovf_evt;
    frame_err_d = ferr_evt;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  // FIFO pointers, occupancy and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign dvalid     = (count_q != '0);
  assign dout       = dvalid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: drives SPI frames like an upstream
// master and compares received bytes and pulses against a queue model.
module tb_spi_slave_rx;

  localparam int H = 6;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       dready = 1'b0;
  logic [7:0] dout;
  logic       dvalid;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int ovf_cnt = 0;
  int ferr_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] got_q[$];

  spi_slave_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .dvalid(dvalid), .dready(dready), .fifo_count(fifo_count),
    .busy(busy), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record consumer handshakes and event pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dvalid && dready) got_q.push_back(dout);
      if (overflow) ovf_cnt++;
      if (frame_err) ferr_cnt++;
      if (dvalid) dv_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Master frame: one lead-in pulse then ndata data pulses, LSB first.
  task automatic send_frame(input logic [7:0] b, input int ndata, input bit close);
    cs = 1'b0;
    repeat (H) @(posedge clk); #1;
    for (int i = 0; i <= ndata; i++) begin
      sclk = 1'b1;
      repeat (2) @(posedge clk); #1;
      if (i == 0)      mosi = 1'b0;
      else if (i <= 8) mosi = b[i-1];
      else             mosi = 1'($urandom);
      repeat (H - 2) @(posedge clk); #1;
      sclk = 1'b0;
      repeat (H) @(posedge clk); #1;
    end
    if (close) cs = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    dready = 1'b1;
    while (fifo_count != 3'd0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    dready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain: fifo_count got %0d expected 0", fifo_count);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (dvalid !== 1'b0)     begin errors++; $display("FAIL rst_dvalid: got %b expected 0", dvalid); end
    checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL rst_dout: got %h expected 00", dout); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got ovf=%b ferr=%b expected 0 0", overflow, frame_err);
    end
    rst = 1'b0;
    settle();
    checks++; if (busy !== 1'b0 || dvalid !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: got busy=%b dvalid=%b expected 0 0", busy, dvalid);
    end
  endtask

  task automatic test_single();
    int ov0, fe0, dv0;
    ov0 = ovf_cnt; fe0 = ferr_cnt; dv0 = dv_cnt;
    got_q.delete();
    dready = 1'b1;
    send_frame(8'hA5, 8, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    settle();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_size: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL single_byte: got %h expected a5", got_q[0]); end
    end
    checks++; if (dv_cnt - dv0 != 1) begin errors++; $display("FAIL single_dvalid_cycles: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (ferr_cnt != fe0 || ovf_cnt != ov0) begin
      errors++; $display("FAIL single_pulses: got ferr=%0d ovf=%0d expected 0 0", ferr_cnt - fe0, ovf_cnt - ov0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
    dready = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_q[$];
    got_q.delete();
    dready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 8, 1'b1);
      settle();
      exp_q.push_back(8'(i));
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", fifo_count); end
    checks++; if (dvalid !== 1'b1 || dout !== 8'h01) begin
      errors++; $display("FAIL fill_head: got dvalid=%b dout=%h expected 1 01", dvalid, dout);
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fill_order_size: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL fill_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] b, x;
    int ov0;
    got_q.delete();
    dready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, 8, 1'b1);
      settle();
      exp_q.push_back(b);
    end
    ov0 = ovf_cnt;
    send_frame(8'hFF, 8, 1'b1);
    settle();
    checks++; if (ovf_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt - ov0); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    checks++; if (dout !== exp_q[0]) begin errors++; $display("FAIL ovf_head: got %h expected %h", dout, exp_q[0]); end
    // Full FIFO, but the consumer takes the head in the very cycle of the push.
    x = 8'($urandom);
    send_frame(x, 8, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    dready = 1'b1;
    @(posedge clk); #1;
    dready = 1'b0;
    settle();
    void'(exp_q.pop_front());
    exp_q.push_back(x);
    checks++; if (ovf_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_with_pop: got %0d pulses expected 1", ovf_cnt - ov0); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_pop_count: got %0d expected 4", fifo_count); end
    got_q.delete();
    drain();
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL ovf_contents_size: got %0d expected 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL ovf_contents[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_short_long();
    int fe0;
    fe0 = ferr_cnt;
    got_q.delete();
    dready = 1'b1;
    send_frame(8'($urandom), 5, 1'b1);
    settle();
    checks++; if (ferr_cnt - fe0 != 1) begin errors++; $display("FAIL short_ferr: got %0d expected 1", ferr_cnt - fe0); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL short_push: got %0d bytes expected 0", got_q.size()); end
    send_frame(8'h3C, 8, 1'b1);
    settle();
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      errors++; $display("FAIL after_short: got %0d bytes head %h expected 1 3c", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    got_q.delete();
    fe0 = ferr_cnt;
    send_frame(8'($urandom), 9, 1'b1);
    settle();
    checks++; if (ferr_cnt - fe0 != 1) begin errors++; $display("FAIL long_ferr: got %0d expected 1", ferr_cnt - fe0); end
    checks++; if (got_q.size() != 0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL long_push: got %0d bytes count %0d expected 0 0", got_q.size(), fifo_count);
    end
    dready = 1'b0;
  endtask

  task automatic test_rst_mid_frame();
    int fe0;
    got_q.delete();
    dready = 1'b1;
    send_frame(8'h5A, 4, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || dvalid !== 1'b0 || dout !== 8'h00 || fifo_count !== 3'd0 ||
                  overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got busy=%b dvalid=%b dout=%h count=%0d ovf=%b ferr=%b expected all 0",
               busy, dvalid, dout, fifo_count, overflow, frame_err);
    end
    cs = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    fe0 = ferr_cnt;
    settle();
    checks++; if (ferr_cnt != fe0 || got_q.size() != 0) begin
      errors++; $display("FAIL mid_rst_abort: got ferr=%0d bytes=%0d expected 0 0", ferr_cnt - fe0, got_q.size());
    end
    send_frame(8'h5A, 8, 1'b1);
    settle();
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A || ferr_cnt != fe0) begin
      errors++; $display("FAIL after_rst_frame: got %0d bytes head %h ferr=%0d expected 1 5a 0",
                         got_q.size(), got_q.size() ? got_q[0] : 8'h00, ferr_cnt - fe0);
    end
    dready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int nd, exp_ferr, fe0, ov0;
    exp_ferr = 0;
    fe0 = ferr_cnt; ov0 = ovf_cnt;
    got_q.delete();
    dready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      nd = ($urandom_range(0, 1) == 0) ? 8 : int'($urandom_range(3, 11));
      send_frame(b, nd, 1'b1);
      settle();
      if (nd == 8) exp_q.push_back(b);
      else         exp_ferr++;
    end
    dready = 1'b0;
    checks++; if (ferr_cnt - fe0 != exp_ferr) begin
      errors++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - fe0, exp_ferr);
    end
    checks++; if (ovf_cnt != ov0) begin errors++; $display("FAIL rand_ovf: got %0d expected 0", ovf_cnt - ov0); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_size: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_short_long();
    test_rst_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO depth in bytes (power of 2, 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per SPI input (2..3).
REQ-003 SHALL use clock clk; reset rst, synchronous, active-high.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sclk  input  1  SPI clock from upstream SPI master, asynchronous to clk, at least 8x slower than clk.
REQ-007 cs  input  1  chip select, active-low, asynchronous.
REQ-008 mosi  input  1  serial data, LSB first, changes after sclk rising edge.
REQ-009 dout  output  8  byte at FIFO head.
REQ-010 dvalid  output  1  FIFO non-empty; dout valid.
REQ-011 dready  input  1  consumer accepts dout when dvalid && dready.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes held.
REQ-013 busy  output  1  frame in progress (synchronized cs low).
REQ-014 overflow  output  1  one-cycle pulse, completed byte dropped because FIFO full.
REQ-015 frame_err  output  1  one-cycle pulse, frame closed with bit count other than 8.

Function
REQ-016 sclk, cs, mosi SHALL each pass through SYNC_STAGES flops; all decoding uses synchronized copies only.
REQ-017 Falling/rising sclk edges and cs falling/rising edges SHALL be detected by comparing last two synchronized samples.
REQ-018 FSM states: IDLE, LEADIN, SHIFT, DONE.
REQ-019 IDLE -> LEADIN on cs falling edge; bit counter cleared, shift register cleared.
REQ-020 LEADIN: first sclk falling edge SHALL be discarded (mosi not yet valid), -> SHIFT.
REQ-021 SHIFT: each sclk falling edge SHALL shift mosi into bit[bitcnt] (LSB first), bitcnt increments; after 8th bit -> DONE.
REQ-022 DONE: further sclk falling edges SHALL be ignored and mark frame as over-length.
REQ-023 cs rising edge SHALL end frame in any non-IDLE state, -> IDLE same cycle.
REQ-024 On cs rising edge in DONE and not over-length: byte SHALL be pushed to FIFO that cycle; dvalid high next cycle if FIFO was empty (latency 1 clk from detected cs rise).
REQ-025 On cs rising edge in LEADIN, SHIFT, or DONE over-length: no push; frame_err pulses 1 cycle.
REQ-026 cs falling edge while not IDLE (glitch) SHALL restart in LEADIN, no push, no error.
REQ-027 sclk edges while cs synchronized high SHALL be ignored.
REQ-028 FIFO first-word-fall-through: dout = oldest byte, dvalid = fifo_count != 0.
REQ-029 Pop when dvalid && dready; dready with FIFO empty SHALL have no effect.
REQ-030 Push and pop same cycle SHALL both occur; fifo_count unchanged, even when full.
REQ-031 Push when full without pop: byte dropped, FIFO contents unchanged, overflow pulses 1 cycle.
REQ-032 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
REQ-033 busy SHALL equal FSM state != IDLE.

Reset
REQ-034 On rst: FSM IDLE, bitcnt 0, shift register 0x00, FIFO empty, pointers 0, fifo_count 0, dvalid 0, dout 0x00, busy 0, overflow 0, frame_err 0.
REQ-035 Synchronizer flops SHALL reset to idle bus levels: sclk 0, cs 1, mosi 0.
REQ-036 rst mid-frame SHALL abort frame with no push and no frame_err; subsequent cs-low frame received normally only after a fresh cs falling edge.
REQ-037 rst takes priority over push, pop and all edge events in the same cycle.

Verification
REQ-038 Upstream master timing, din 0xA5, dready held 1 -> one byte 0xA5, dvalid 1 cycle, frame_err 0, overflow 0.
REQ-039 Four frames 0x01,0x02,0x03,0x04, dready 0 -> fifo_count 4; then dready 1 -> dout 01,02,03,04 in order, fifo_count 0.
REQ-040 FIFO full (4 bytes), fifth frame 0xFF, dready 0 -> overflow pulse, fifo_count 4, contents unchanged; same with dready 1 at push cycle -> no overflow, 0xFF enters.
REQ-041 cs raised after 5 data bits -> frame_err pulse, no push; next full frame 0x3C received correctly.
REQ-042 9 data falling edges before cs rise -> frame_err pulse, no push.
REQ-043 rst asserted after 4 bits of 0x5A -> all outputs at reset values, no push; next frame 0x5A received correctly.
